// File: rtl/dma_fifo_lvl.sv
// rtl/dma_fifo_lvl.sv - show-ahead DMA staging FIFO with level, watermarks and sticky error flags
`ifndef DMA_FIFO_DEPTH
`define DMA_FIFO_DEPTH 16
`endif
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 32
`endif

module dma_fifo_lvl #(
  parameter int SLOTS = `DMA_FIFO_DEPTH,
  parameter int WIDTH = `DMA_DATA_WIDTH,
  parameter int LVL_W = $clog2(SLOTS + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear_i,
  input  logic             write_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             read_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o,
  input  logic [LVL_W-1:0] af_thresh_i,
  input  logic [LVL_W-1:0] ae_thresh_i,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [WIDTH-1:0] mem [0:SLOTS-1];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             ovf_q, unf_q;
  logic             wr_acc, rd_acc;

  assign full_o         = (level_q == LVL_W'(SLOTS));
  assign empty_o        = (level_q == '0);
  assign level_o        = level_q;
  assign almost_full_o  = (level_q >= af_thresh_i);
  assign almost_empty_o = (level_q <= ae_thresh_i);
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;
  assign data_o         = empty_o ? '0 : mem[rd_ptr];

  // A pop frees the slot in the same edge, so a full FIFO may still take a push.
  assign rd_acc = read_i & ~empty_o;
  assign wr_acc = write_i & (~full_o | read_i);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(SLOTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn || clear_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      if (write_i && full_o && !read_i) ovf_q <= 1'b1;
      if (read_i && empty_o)            unf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !clear_i && wr_acc) mem[wr_ptr] <= data_i;
  end

`ifndef NO_ASSERTIONS
  if (SLOTS < 1) begin : g_bad_slots
    $error("dma_fifo_lvl: SLOTS must be >= 1");
  end

  a_level_bound: assert property (@(posedge clk) level_q <= LVL_W'(SLOTS));
`endif

endmodule

// File: tb/tb_dma_fifo_lvl.sv
// tb/tb_dma_fifo_lvl.sv - directed self-checking bench for dma_fifo_lvl (SLOTS=5 and SLOTS=1)
module tb_dma_fifo_lvl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // SLOTS=5 instance
  logic       rstn5, clr5, w5, r5;
  logic [7:0] d5, q5;
  logic [2:0] lvl5, af5, ae5;
  logic       full5, empty5, afo5, aeo5, ovf5, unf5;

  // SLOTS=1 instance
  logic       rstn1, clr1, w1, r1;
  logic [7:0] d1, q1;
  logic [0:0] lvl1, af1, ae1;
  logic       full1, empty1, afo1, aeo1, ovf1, unf1;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] model [$];

  dma_fifo_lvl #(.SLOTS(5), .WIDTH(8)) u_dut5 (
    .clk(clk), .rstn(rstn5), .clear_i(clr5), .write_i(w5), .data_i(d5),
    .read_i(r5), .data_o(q5), .full_o(full5), .empty_o(empty5), .level_o(lvl5),
    .af_thresh_i(af5), .ae_thresh_i(ae5), .almost_full_o(afo5),
    .almost_empty_o(aeo5), .overflow_o(ovf5), .underflow_o(unf5)
  );

  dma_fifo_lvl #(.SLOTS(1), .WIDTH(8)) u_dut1 (
    .clk(clk), .rstn(rstn1), .clear_i(clr1), .write_i(w1), .data_i(d1),
    .read_i(r1), .data_o(q1), .full_o(full1), .empty_o(empty1), .level_o(lvl1),
    .af_thresh_i(af1), .ae_thresh_i(ae1), .almost_full_o(afo1),
    .almost_empty_o(aeo1), .overflow_o(ovf1), .underflow_o(unf1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn5 = 1'b0; clr5 = 1'b0; w5 = 1'b0; r5 = 1'b0; d5 = 8'h00; af5 = 3'd4; ae5 = 3'd1;
    rstn1 = 1'b0; clr1 = 1'b0; w1 = 1'b0; r1 = 1'b0; d1 = 8'h00; af1 = 1'b1; ae1 = 1'b0;
    step(); step();
    rstn5 = 1'b1; rstn1 = 1'b1;

    check("rst_empty", empty5, 1);
    check("rst_full", full5, 0);
    check("rst_level", lvl5, 0);
    check("rst_data", q5, 0);
    check("rst_ae", aeo5, 1);
    check("rst_af", afo5, 0);
    check("rst_ovf", ovf5, 0);
    check("rst_unf", unf5, 0);

    // fill 0x11..0x15
    for (int i = 0; i < 5; i++) begin
      w5 = 1'b1; d5 = 8'h11 + 8'(i);
      step();
      check("fill_level", lvl5, i + 1);
      check("fill_head", q5, 8'h11);
      check("fill_af", afo5, (i + 1 >= 4) ? 1 : 0);
      check("fill_ae", aeo5, (i + 1 <= 1) ? 1 : 0);
      check("fill_full", full5, (i == 4) ? 1 : 0);
    end

    // push into full FIFO without pop is dropped
    w5 = 1'b1; d5 = 8'h66; r5 = 1'b0;
    step();
    w5 = 1'b0;
    check("ovf_set", ovf5, 1);
    check("ovf_level", lvl5, 5);
    check("ovf_head", q5, 8'h11);
    step();
    check("ovf_sticky", ovf5, 1);

    for (int i = 0; i < 5; i++) begin
      r5 = 1'b1;
      check("drain_data", q5, 8'h11 + 8'(i));
      step();
      check("drain_level", lvl5, 4 - i);
    end
    r5 = 1'b0;
    check("drain_empty", empty5, 1);
    check("drain_zero", q5, 0);
    check("drain_ovf_held", ovf5, 1);

    clr5 = 1'b1;
    step();
    clr5 = 1'b0;
    check("clr_ovf", ovf5, 0);

    // full + simultaneous push/pop across pointer wrap
    model.delete();
    for (int i = 0; i < 5; i++) begin
      w5 = 1'b1; d5 = 8'h21 + 8'(i);
      model.push_back(d5);
      step();
    end
    check("wrap_full", full5, 1);
    for (int k = 0; k < 7; k++) begin
      w5 = 1'b1; r5 = 1'b1; d5 = 8'h70 + 8'(k);
      check("wrap_pop", q5, model[0]);
      void'(model.pop_front());
      model.push_back(d5);
      step();
      check("wrap_level", lvl5, 5);
    end
    w5 = 1'b0;
    check("wrap_no_ovf", ovf5, 0);
    for (int i = 0; i < 5; i++) begin
      r5 = 1'b1;
      check("wrap_drain", q5, model[0]);
      void'(model.pop_front());
      step();
    end
    r5 = 1'b0;
    check("wrap_empty", empty5, 1);

    // push+pop on empty: push only, underflow
    w5 = 1'b1; r5 = 1'b1; d5 = 8'hA5;
    step();
    w5 = 1'b0; r5 = 1'b0;
    check("unf_set", unf5, 1);
    check("unf_level", lvl5, 1);
    check("unf_data", q5, 8'hA5);
    r5 = 1'b1;
    step();
    r5 = 1'b0;

    // clear at level 3 with concurrent push
    for (int i = 0; i < 3; i++) begin
      w5 = 1'b1; d5 = 8'h30 + 8'(i);
      step();
    end
    check("pre_clr_level", lvl5, 3);
    clr5 = 1'b1; w5 = 1'b1; d5 = 8'h99; ae5 = 3'd0;
    step();
    clr5 = 1'b0; w5 = 1'b0;
    check("clr_level", lvl5, 0);
    check("clr_empty", empty5, 1);
    check("clr_unf", unf5, 0);
    check("clr_ovf2", ovf5, 0);
    check("clr_ae0", aeo5, 1);
    r5 = 1'b1;
    step();
    r5 = 1'b0;
    check("clr_pop_empty", empty5, 1);
    check("clr_pop_data", q5, 0);
    af5 = 3'd0;
    #1;
    check("af_zero_thresh", afo5, 1);

    // SLOTS=1
    w1 = 1'b1; d1 = 8'h3C;
    step();
    w1 = 1'b0;
    check("s1_full", full1, 1);
    check("s1_level", lvl1, 1);
    check("s1_data", q1, 8'h3C);
    w1 = 1'b1; r1 = 1'b1; d1 = 8'h4D;
    check("s1_pop_data", q1, 8'h3C);
    step();
    w1 = 1'b0; r1 = 1'b0;
    check("s1_swap_data", q1, 8'h4D);
    check("s1_swap_level", lvl1, 1);
    check("s1_no_ovf", ovf1, 0);
    w1 = 1'b1; d1 = 8'h5E; rstn1 = 1'b0;
    step();
    w1 = 1'b0; rstn1 = 1'b1;
    check("s1_rst_empty", empty1, 1);
    check("s1_rst_level", lvl1, 0);
    check("s1_rst_data", q1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
